// File: rtl/bip_exec_ctrl.sv
// Execution sequencer for the BIP accumulator CPU: loads instruction memory from
// UART bytes, runs / single-steps / clears the core and dumps PC, ACC and cycle count.
module bip_exec_ctrl #(
    parameter int PC_BITS   = 11,
    parameter int DATA_BITS = 16,
    parameter int CYC_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 im_wr_en,
    output logic [PC_BITS-1:0]   im_wr_addr,
    output logic [15:0]          im_wr_data,
    output logic                 cpu_en,
    output logic                 cpu_clr,
    input  logic                 h_flg,
    input  logic [PC_BITS-1:0]   pc,
    input  logic [DATA_BITS-1:0] acc,
    output logic                 busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LD_CNT, ST_LD_HI, ST_LD_LO, ST_CLR,
        ST_RUN, ST_STEP, ST_DUMP_SEND, ST_DUMP_WAIT
    } state_t;

    localparam logic [CYC_BITS-1:0] CYC_MAX = {CYC_BITS{1'b1}};
    localparam logic [CYC_BITS-1:0] CYC_ONE = {{(CYC_BITS-1){1'b0}}, 1'b1};
    localparam logic [PC_BITS-1:0]  PC_ONE  = {{(PC_BITS-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [CYC_BITS-1:0]   cyc_r;
    logic [7:0]            words_left_r;
    logic [PC_BITS-1:0]    addr_r;
    logic [7:0]            hi_r;
    logic [47:0]           frame_r;
    logic [2:0]            byte_idx_r;
    logic                  snap_r;
    logic                  wait_first_r;
    logic [7:0]            tx_data_r;
    logic                  tx_start_r;
    logic                  im_wr_en_r;
    logic [PC_BITS-1:0]    im_wr_addr_r;
    logic [15:0]           im_wr_data_r;
    logic                  cpu_clr_r;
    logic                  cyc_sat_s;
    logic                  cpu_en_s;

    assign cyc_sat_s = (cyc_r == CYC_MAX);

    // CPU enable decodes straight from state so the core stops in the same cycle it halts.
    always_comb begin
        cpu_en_s = 1'b0;
        case (state_r)
            ST_RUN:  cpu_en_s = !h_flg && !cyc_sat_s;
            ST_STEP: cpu_en_s = !h_flg;
            default: cpu_en_s = 1'b0;
        endcase
    end

    // Sequencer state, load/dump datapath and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cyc_r        <= {CYC_BITS{1'b0}};
            words_left_r <= 8'h00;
            addr_r       <= {PC_BITS{1'b0}};
            hi_r         <= 8'h00;
            frame_r      <= 48'h0;
            byte_idx_r   <= 3'd0;
            snap_r       <= 1'b0;
            wait_first_r <= 1'b0;
            tx_data_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            im_wr_en_r   <= 1'b0;
            im_wr_addr_r <= {PC_BITS{1'b0}};
            im_wr_data_r <= 16'h0000;
            cpu_clr_r    <= 1'b0;
        end else begin
            im_wr_en_r <= 1'b0;
            tx_start_r <= 1'b0;
            cpu_clr_r  <= 1'b0;
            if (cpu_en_s && !cyc_sat_s) begin
                cyc_r <= cyc_r + CYC_ONE;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            8'h4C: state_r <= ST_LD_CNT;
                            8'h52: state_r <= ST_RUN;
                            8'h53: state_r <= ST_STEP;
                            8'h44: begin
                                state_r    <= ST_DUMP_SEND;
                                snap_r     <= 1'b1;
                                byte_idx_r <= 3'd0;
                            end
                            8'h43: begin
                                state_r   <= ST_CLR;
                                cpu_clr_r <= 1'b1;
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_LD_CNT: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h00) begin
                            state_r <= ST_IDLE;
                        end else begin
                            words_left_r <= rx_data;
                            addr_r       <= {PC_BITS{1'b0}};
                            state_r      <= ST_LD_HI;
                        end
                    end
                end
                ST_LD_HI: begin
                    if (rx_valid) begin
                        hi_r    <= rx_data;
                        state_r <= ST_LD_LO;
                    end
                end
                ST_LD_LO: begin
                    if (rx_valid) begin
                        im_wr_en_r   <= 1'b1;
                        im_wr_addr_r <= addr_r;
                        im_wr_data_r <= {hi_r, rx_data};
                        addr_r       <= addr_r + PC_ONE;
                        words_left_r <= words_left_r - 8'd1;
                        if (words_left_r == 8'd1) begin
                            state_r   <= ST_CLR;
                            cpu_clr_r <= 1'b1;
                        end else begin
                            state_r <= ST_LD_HI;
                        end
                    end
                end
                ST_CLR: begin
                    cyc_r   <= {CYC_BITS{1'b0}};
                    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (h_flg || cyc_sat_s) begin
                        state_r    <= ST_DUMP_SEND;
                        snap_r     <= 1'b1;
                        byte_idx_r <= 3'd0;
                    end
                end
                ST_STEP: begin
                    state_r    <= ST_DUMP_SEND;
                    snap_r     <= 1'b1;
                    byte_idx_r <= 3'd0;
                end
                ST_DUMP_SEND: begin
                    // First cycle here captures the frame, after the last enabled edge settled.
                    if (snap_r) begin
                        frame_r <= {16'(pc), 16'(acc), 16'(cyc_r)};
                        snap_r  <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_data_r    <= frame_r[47:40];
                        frame_r      <= {frame_r[39:0], 8'h00};
                        tx_start_r   <= 1'b1;
                        wait_first_r <= 1'b1;
                        state_r      <= ST_DUMP_WAIT;
                    end
                end
                ST_DUMP_WAIT: begin
                    // tx_busy lags tx_start by a cycle, so its first sample here is stale.
                    if (wait_first_r) begin
                        wait_first_r <= 1'b0;
                    end else if (!tx_busy) begin
                        if (byte_idx_r == 3'd5) begin
                            byte_idx_r <= 3'd0;
                            state_r    <= ST_IDLE;
                        end else begin
                            byte_idx_r <= byte_idx_r + 3'd1;
                            state_r    <= ST_DUMP_SEND;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_r;
    assign tx_start   = tx_start_r;
    assign im_wr_en   = im_wr_en_r;
    assign im_wr_addr = im_wr_addr_r;
    assign im_wr_data = im_wr_data_r;
    assign cpu_clr    = cpu_clr_r;
    assign cpu_en     = cpu_en_s;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_bip_exec_ctrl.sv
// Scoreboard bench for bip_exec_ctrl: a toy BIP core and UART model drive the DUT,
// an ISA-level reference model predicts writes, dump bytes and enable/clear pulse counts.
module tb_bip_exec_ctrl;
    localparam int PCB  = 11;
    localparam int CB   = 7;
    localparam int CMAX = 127;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic tx_start, tx_busy, im_wr_en, cpu_en, cpu_clr, h_flg, busy;
    logic [PCB-1:0] im_wr_addr, cpu_pc;
    logic [15:0] im_wr_data, cpu_acc;

    always #5 clk = ~clk;

    bip_exec_ctrl #(.PC_BITS(PCB), .DATA_BITS(16), .CYC_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
        .cpu_en(cpu_en), .cpu_clr(cpu_clr), .h_flg(h_flg),
        .pc(cpu_pc), .acc(cpu_acc), .busy(busy)
    );

    // Toy core: op 0 HLT, 3 LDI, 5 ADDI, anything else is a no-op.
    logic [15:0] imem [0:2047] = '{default: 16'h0000};
    logic [15:0] cur_w;
    assign cur_w = imem[cpu_pc];
    assign h_flg = (cur_w[15:11] == 5'd0);

    always @(posedge clk) begin
        if (im_wr_en) imem[im_wr_addr] <= im_wr_data;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_pc <= '0; cpu_acc <= 16'h0000;
        end else if (cpu_clr) begin
            cpu_pc <= '0; cpu_acc <= 16'h0000;
        end else if (cpu_en) begin
            case (cur_w[15:11])
                5'd3: cpu_acc <= {5'd0, cur_w[10:0]};
                5'd5: cpu_acc <= cpu_acc + {5'd0, cur_w[10:0]};
                default: cpu_acc <= cpu_acc;
            endcase
            cpu_pc <= cpu_pc + 11'd1;
        end
    end

    // UART TX: busy from the cycle after tx_start for hold_cycles+1 cycles.
    int hold_cycles = 3;
    int tx_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0; tx_cnt <= 0;
        end else if (tx_start) begin
            tx_busy <= 1'b1; tx_cnt <= hold_cycles;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    // Scoreboard state
    typedef struct { int en; int clr; bit tmo; string name; } sync_t;
    logic [26:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    sync_t       sync_q[$];
    int errors = 0;
    int checks = 0;

    // Monitor: the only process that compares and counts.
    initial begin
        int en_seen, clr_seen;
        bit rst_seen;
        sync_t s;
        logic [26:0] w;
        logic [7:0] b;
        en_seen = 0; clr_seen = 0; rst_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (!rst_seen) begin
                    checks++;
                    if ({tx_start, tx_data, im_wr_en, im_wr_addr, im_wr_data, cpu_en, cpu_clr, busy} != '0) begin
                        errors++;
                        $display("FAIL reset_outputs: got tx_start=%0b im_wr_en=%0b cpu_en=%0b cpu_clr=%0b busy=%0b, expected all 0",
                                 tx_start, im_wr_en, cpu_en, cpu_clr, busy);
                    end
                    rst_seen = 1'b1;
                end
                en_seen = 0; clr_seen = 0;
            end else begin
                rst_seen = 1'b0;
                if (cpu_en) en_seen++;
                if (cpu_clr) clr_seen++;
                if (im_wr_en) begin
                    checks++;
                    if (cpu_en) begin
                        errors++;
                        $display("FAIL wr_vs_en: im_wr_en and cpu_en both 1, expected exclusive");
                    end else if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL im_write: got unexpected write addr=%0d data=%h", im_wr_addr, im_wr_data);
                    end else begin
                        w = exp_wr.pop_front();
                        if ({im_wr_addr, im_wr_data} != w) begin
                            errors++;
                            $display("FAIL im_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                     im_wr_addr, im_wr_data, w[26:16], w[15:0]);
                        end
                    end
                end
                if (tx_start) begin
                    checks++;
                    if (tx_busy) begin
                        errors++;
                        $display("FAIL tx_flow: tx_start while tx_busy=1, expected tx_busy=0");
                    end
                    checks++;
                    if (exp_tx.size() == 0) begin
                        errors++;
                        $display("FAIL tx_byte: got unexpected byte %h", tx_data);
                    end else begin
                        b = exp_tx.pop_front();
                        if (tx_data != b) begin
                            errors++;
                            $display("FAIL tx_byte: got %h expected %h", tx_data, b);
                        end
                    end
                end
                if (sync_q.size() > 0) begin
                    s = sync_q.pop_front();
                    checks += 4;
                    if (s.tmo || busy) begin
                        errors++;
                        $display("FAIL %s_idle: got busy=%0b timeout=%0b, expected idle", s.name, busy, s.tmo);
                    end
                    if (en_seen != s.en) begin
                        errors++;
                        $display("FAIL %s_cpu_en: got %0d pulses expected %0d", s.name, en_seen, s.en);
                    end
                    if (clr_seen != s.clr) begin
                        errors++;
                        $display("FAIL %s_cpu_clr: got %0d pulses expected %0d", s.name, clr_seen, s.clr);
                    end
                    if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
                        errors++;
                        $display("FAIL %s_pending: got %0d tx and %0d writes outstanding, expected 0",
                                 s.name, exp_tx.size(), exp_wr.size());
                    end
                    en_seen = 0; clr_seen = 0;
                end
            end
        end
    end

    // Reference model: instruction-level execution of the loaded program.
    logic [15:0] m_mem [0:2047] = '{default: 16'h0000};
    logic [10:0] m_pc = 11'd0;
    logic [15:0] m_acc = 16'h0000;
    int m_cnt = 0;
    logic [15:0] prog_q[$];

    function automatic bit m_halted();
        logic [15:0] w;
        w = m_mem[m_pc];
        return (w[15:11] == 5'd0);
    endfunction

    task automatic m_exec();
        logic [15:0] w;
        w = m_mem[m_pc];
        if (w[15:11] == 5'd3) m_acc = {5'd0, w[10:0]};
        else if (w[15:11] == 5'd5) m_acc = m_acc + {5'd0, w[10:0]};
        m_pc = m_pc + 11'd1;
    endtask

    task automatic push16(input logic [15:0] v);
        exp_tx.push_back(v[15:8]);
        exp_tx.push_back(v[7:0]);
    endtask

    task automatic push_frame();
        logic [15:0] c;
        c = 16'(m_cnt);
        push16({5'd0, m_pc});
        push16(m_acc);
        push16(c);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int en, input int clr, input string name);
        sync_t s;
        s.tmo = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!busy) begin s.tmo = 1'b0; break; end
        end
        s.en = en; s.clr = clr; s.name = name;
        sync_q.push_back(s);
    endtask

    task automatic do_load(input string name);
        int n;
        n = prog_q.size();
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = prog_q[i];
            m_mem[i] = w;
            exp_wr.push_back({11'(i), w});
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        if (n > 0) begin m_pc = 11'd0; m_acc = 16'h0000; m_cnt = 0; end
        finish_cmd(0, (n > 0) ? 1 : 0, name);
    endtask

    task automatic do_run(input string name);
        int steps;
        steps = 0;
        send_byte(8'h52);
        while (!m_halted() && m_cnt != CMAX) begin
            m_exec(); m_cnt++; steps++;
        end
        push_frame();
        finish_cmd(steps, 0, name);
    endtask

    task automatic do_step(input string name);
        int en;
        en = 0;
        send_byte(8'h53);
        if (!m_halted()) begin
            m_exec(); en = 1;
            if (m_cnt != CMAX) m_cnt++;
        end
        push_frame();
        finish_cmd(en, 0, name);
    endtask

    task automatic do_dump(input string name);
        send_byte(8'h44);
        push_frame();
        finish_cmd(0, 0, name);
    endtask

    task automatic do_clear(input string name);
        send_byte(8'h43);
        m_pc = 11'd0; m_acc = 16'h0000; m_cnt = 0;
        finish_cmd(0, 1, name);
    endtask

    task automatic do_junk(input logic [7:0] b, input string name);
        sync_t s;
        send_byte(b);
        s.en = 0; s.clr = 0; s.tmo = 1'b0; s.name = name;
        sync_q.push_back(s);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        m_pc = 11'd0; m_acc = 16'h0000; m_cnt = 0;
    endtask

    initial begin
        logic [7:0] jb;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_dump("reset_dump");
        do_junk(8'h7A, "junk_idle");

        prog_q = '{16'h1805, 16'h2803, 16'h0000};
        do_load("load3");
        do_run("run3");

        do_clear("clear");
        do_step("step1");
        do_step("step2");
        do_step("step3_halted");

        // 'R' arriving mid-dump must be dropped, with a slow 20-cycle UART.
        hold_cycles = 19;
        send_byte(8'h44);
        push_frame();
        repeat (3) @(posedge clk);
        send_byte(8'h52);
        finish_cmd(0, 0, "dump_drop_run");
        hold_cycles = 3;

        prog_q = {};
        do_load("load_zero");

        for (int it = 0; it < 14; it++) begin
            hold_cycles = $urandom_range(0, 6);
            case ($urandom_range(0, 5))
                0: begin
                    int n;
                    logic [4:0] ops [4];
                    ops = '{5'd0, 5'd3, 5'd5, 5'd7};
                    n = $urandom_range(1, 8);
                    prog_q = {};
                    for (int i = 0; i < n; i++)
                        prog_q.push_back({ops[$urandom_range(0, 3)], 11'($urandom_range(0, 2047))});
                    prog_q.push_back(16'h0000);
                    do_load("rnd_load");
                end
                1: do_run("rnd_run");
                2: do_step("rnd_step");
                3: do_dump("rnd_dump");
                4: do_clear("rnd_clear");
                default: begin
                    jb = 8'($urandom_range(0, 255));
                    while (jb == 8'h4C || jb == 8'h52 || jb == 8'h53 || jb == 8'h44 || jb == 8'h43)
                        jb = jb + 8'd1;
                    do_junk(jb, "rnd_junk");
                end
            endcase
        end

        // Saturation: 255 x ADDI 1, counter tops out before any halt.
        hold_cycles = 1;
        prog_q = {};
        for (int i = 0; i < 255; i++) prog_q.push_back(16'h2801);
        do_load("load_sat");
        do_run("run_sat");
        do_run("run_at_sat");
        do_step("step_at_sat");

        // Reset while in LD_LO: first word stays written.
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h18);
        send_byte(8'h09);
        m_mem[0] = 16'h1809;
        exp_wr.push_back({11'd0, 16'h1809});
        send_byte(8'h28);
        pulse_reset();
        do_dump("dump_after_ldreset");
        do_run("run_after_ldreset");

        // Reset in RUN, then the kept program runs again from scratch.
        prog_q = {};
        for (int i = 0; i < 40; i++) prog_q.push_back(16'h2801);
        prog_q.push_back(16'h0000);
        do_load("load40");
        send_byte(8'h52);
        repeat (10) @(posedge clk);
        pulse_reset();
        do_dump("dump_after_runreset");
        do_run("run_after_runreset");

        for (int i = 0; i < 200 && sync_q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
